// File: rtl/branch_predictor.sv
`default_nettype none
// branch_predictor: direct-mapped BTB with static, bimodal or gshare direction
// prediction, trained from resolved-branch reports, plus saturating statistics.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int MODE    = 1,
  parameter int GHR_W   = $clog2(ENTRIES),
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [31:0]      lookup_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_npc,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  input  logic [31:0]      upd_pred_npc,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);
  localparam int               IDX_W    = $clog2(ENTRIES);
  localparam int               TAG_W    = 30 - IDX_W;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam bit               GSHARE   = (MODE == 2);
  localparam bit               TRAIN_EN = (MODE != 0);

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [31:0]        target_mem [ENTRIES];
  logic [CTR_W-1:0]   ctr_mem    [ENTRIES];
  logic [GHR_W-1:0]   ghr;
  logic [GHR_W-1:0]   ghr_next;
  logic [IDX_W-1:0]   hist;

  logic [IDX_W-1:0]   lk_idx, lk_cidx;
  logic [TAG_W-1:0]   lk_tag;
  logic               lk_hit;

  logic [IDX_W-1:0]   up_idx, up_cidx;
  logic [TAG_W-1:0]   up_tag;
  logic               up_hit;
  logic [CTR_W-1:0]   up_ctr, ctr_inc, ctr_dec;
  logic               train;
  logic [31:0]        actual_npc;

  // The direction only reaches the datapath through the npc it selected.
  logic unused_pred_taken;
  assign unused_pred_taken = upd_pred_taken;

  // History only perturbs the counter index; the BTB always uses the plain index.
  assign hist = GSHARE ? IDX_W'(ghr) : '0;

  generate
    if (GHR_W == 1) begin : g_ghr_one
      assign ghr_next = upd_taken;
    end else begin : g_ghr_shift
      assign ghr_next = {ghr[GHR_W-2:0], upd_taken};
    end
  endgenerate

  assign lk_idx  = lookup_pc[IDX_W+1:2];
  assign lk_tag  = lookup_pc[31:IDX_W+2];
  assign lk_cidx = lk_idx ^ hist;
  assign lk_hit  = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);

  assign pred_taken = TRAIN_EN && lk_hit && ctr_mem[lk_cidx][CTR_W-1];
  assign pred_npc   = pred_taken ? target_mem[lk_idx] : lookup_pc + 32'd4;

  assign actual_npc = upd_taken ? upd_target : upd_pc + 32'd4;
  assign mispredict = upd_valid && (upd_pred_npc != actual_npc);

  assign up_idx  = upd_pc[IDX_W+1:2];
  assign up_tag  = upd_pc[31:IDX_W+2];
  assign up_cidx = up_idx ^ hist;
  assign up_hit  = valid[up_idx] && (tag_mem[up_idx] == up_tag);
  assign up_ctr  = ctr_mem[up_cidx];
  assign ctr_inc = (up_ctr == CTR_MAX) ? up_ctr : up_ctr + CTR_W'(1);
  assign ctr_dec = (up_ctr == '0) ? up_ctr : up_ctr - CTR_W'(1);
  assign train   = upd_valid && TRAIN_EN;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      valid <= '0;
      ghr   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_mem[i] <= '0;
      end
    end else if (train) begin
      if (upd_taken) begin
        valid[up_idx]    <= 1'b1;
        ctr_mem[up_cidx] <= up_hit ? ctr_inc : CTR_WEAK;
      end else if (up_hit) begin
        ctr_mem[up_cidx] <= ctr_dec;
      end
      if (GSHARE) begin
        ghr <= ghr_next;
      end
    end
  end

  // Tag and target need no reset: valid gates every use of them.
  always_ff @(posedge CLK) begin
    if (nRST && train && upd_taken) begin
      tag_mem[up_idx]    <= up_tag;
      target_mem[up_idx] <= upd_target;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (upd_valid && (branch_cnt != CNT_MAX)) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (mispredict && (mispred_cnt != CNT_MAX)) begin
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// tb_branch_predictor: bimodal, gshare and static instances share one stimulus
// stream and are checked every cycle against a table-level reference model.
module tb_branch_predictor;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] lookup_pc, upd_pc, upd_target, upd_pred_npc;
  logic        upd_valid, upd_taken, upd_pred_taken;

  logic        pt0, pt1, pt2, mp0, mp1, mp2;
  logic [31:0] pn0, pn1, pn2, bc0, bc1, mc0, mc1;
  logic [1:0]  bc2, mc2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(16), .CTR_W(2), .MODE(1), .CNT_W(32)) u0 (
    .CLK(clk), .nRST(nrst), .lookup_pc(lookup_pc), .pred_taken(pt0), .pred_npc(pn0),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_npc(upd_pred_npc), .mispredict(mp0),
    .branch_cnt(bc0), .mispred_cnt(mc0));

  branch_predictor #(.ENTRIES(16), .CTR_W(1), .MODE(2), .GHR_W(2), .CNT_W(32)) u1 (
    .CLK(clk), .nRST(nrst), .lookup_pc(lookup_pc), .pred_taken(pt1), .pred_npc(pn1),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_npc(upd_pred_npc), .mispredict(mp1),
    .branch_cnt(bc1), .mispred_cnt(mc1));

  branch_predictor #(.ENTRIES(8), .CTR_W(3), .MODE(0), .CNT_W(2)) u2 (
    .CLK(clk), .nRST(nrst), .lookup_pc(lookup_pc), .pred_taken(pt2), .pred_npc(pn2),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_npc(upd_pred_npc), .mispredict(mp2),
    .branch_cnt(bc2), .mispred_cnt(mc2));

  // Per-instance configuration
  function automatic int p_mode(int k); return (k == 0) ? 1 : (k == 1) ? 2 : 0; endfunction
  function automatic int p_ent(int k);  return (k == 2) ? 8 : 16; endfunction
  function automatic int p_iw(int k);   return (k == 2) ? 3 : 4; endfunction
  function automatic int p_ctrw(int k); return (k == 0) ? 2 : (k == 1) ? 1 : 3; endfunction
  function automatic int p_cntw(int k); return (k == 2) ? 2 : 32; endfunction
  localparam int GHR_BITS = 2;

  function automatic logic [31:0] got_pt(int k);
    return (k == 0) ? {31'd0, pt0} : (k == 1) ? {31'd0, pt1} : {31'd0, pt2};
  endfunction
  function automatic logic [31:0] got_pn(int k); return (k == 0) ? pn0 : (k == 1) ? pn1 : pn2; endfunction
  function automatic logic [31:0] got_mp(int k);
    return (k == 0) ? {31'd0, mp0} : (k == 1) ? {31'd0, mp1} : {31'd0, mp2};
  endfunction
  function automatic logic [31:0] got_bc(int k); return (k == 0) ? bc0 : (k == 1) ? bc1 : {30'd0, bc2}; endfunction
  function automatic logic [31:0] got_mc(int k); return (k == 0) ? mc0 : (k == 1) ? mc1 : {30'd0, mc2}; endfunction

  // Reference model state
  bit              m_valid [N][16];
  longint unsigned m_tag   [N][16];
  logic [31:0]     m_tgt   [N][16];
  int              m_ctr   [N][16];
  int              m_ghr   [N];
  longint unsigned m_bc    [N];
  longint unsigned m_mc    [N];
  bit              started = 1'b0;

  function automatic int m_idx(int k, logic [31:0] pc);
    return int'((pc >> 2) % p_ent(k));
  endfunction
  function automatic int m_cidx(int k, logic [31:0] pc);
    return (p_mode(k) == 2) ? (m_idx(k, pc) ^ m_ghr[k]) : m_idx(k, pc);
  endfunction
  function automatic bit m_hit(int k, logic [31:0] pc);
    int i;
    i = m_idx(k, pc);
    return m_valid[k][i] && (m_tag[k][i] == longint'(pc >> (p_iw(k) + 2)));
  endfunction
  function automatic bit m_pred(int k, logic [31:0] pc);
    return (p_mode(k) != 0) && m_hit(k, pc) && (m_ctr[k][m_cidx(k, pc)] >= (1 << (p_ctrw(k) - 1)));
  endfunction
  function automatic logic [31:0] m_npc(int k, logic [31:0] pc);
    return m_pred(k, pc) ? m_tgt[k][m_idx(k, pc)] : pc + 32'd4;
  endfunction
  function automatic bit m_mis();
    return upd_valid && (upd_pred_npc != (upd_taken ? upd_target : upd_pc + 32'd4));
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s u%0d: got %h expected %h (t=%0t)", name, k, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[k][i] = 1'b0;
        m_ctr[k][i]   = 0;
      end
      m_ghr[k] = 0;
      m_bc[k]  = 0;
      m_mc[k]  = 0;
    end
    started = 1'b1;
  endtask

  task automatic model_update();
    bit              mis, h;
    int              i, c, top;
    longint unsigned cmax;
    mis = m_mis();
    for (int k = 0; k < N; k++) begin
      cmax = (64'd1 << p_cntw(k)) - 64'd1;
      if (m_bc[k] < cmax) m_bc[k]++;
      if (mis && (m_mc[k] < cmax)) m_mc[k]++;
      if (p_mode(k) != 0) begin
        i   = m_idx(k, upd_pc);
        c   = m_cidx(k, upd_pc);
        h   = m_hit(k, upd_pc);
        top = (1 << p_ctrw(k)) - 1;
        if (upd_taken) begin
          m_tgt[k][i] = upd_target;
          if (h) begin
            if (m_ctr[k][c] < top) m_ctr[k][c]++;
          end else begin
            m_valid[k][i] = 1'b1;
            m_tag[k][i]   = longint'(upd_pc >> (p_iw(k) + 2));
            m_ctr[k][c]   = 1 << (p_ctrw(k) - 1);
          end
        end else if (h && (m_ctr[k][c] > 0)) begin
          m_ctr[k][c]--;
        end
        if (p_mode(k) == 2) m_ghr[k] = ((m_ghr[k] << 1) | int'(upd_taken)) % (1 << GHR_BITS);
      end
    end
  endtask

  // Compare against pre-edge model state, then advance the model across the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        for (int k = 0; k < N; k++) begin
          chk("pred_taken", k, got_pt(k), {31'd0, m_pred(k, lookup_pc)});
          chk("pred_npc", k, got_pn(k), m_npc(k, lookup_pc));
          chk("mispredict", k, got_mp(k), {31'd0, m_mis()});
          chk("branch_cnt", k, got_bc(k), 32'(m_bc[k]));
          chk("mispred_cnt", k, got_mc(k), 32'(m_mc[k]));
        end
      end
      if (!nrst) model_reset();
      else if (upd_valid) model_update();
    end
  end

  task automatic go(input logic [31:0] lk, input logic v, input logic [31:0] pc, input logic tk,
                    input logic [31:0] tgt, input logic [31:0] pnpc, input logic rn);
    @(posedge clk);
    #1;
    nrst           = rn;
    lookup_pc      = lk;
    upd_valid      = v;
    upd_pc         = pc;
    upd_taken      = tk;
    upd_target     = tgt;
    upd_pred_npc   = pnpc;
    upd_pred_taken = (pnpc != pc + 32'd4);
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] rpc();
    logic [31:0] r;
    r = $urandom;
    if (r[31:30] == 2'b00) return r & 32'hFFFF_FFFC;
    return r & 32'h0000_00FC;
  endfunction

  logic [31:0] ra, rb, rt, rp;

  initial begin
    nrst = 1'b0; lookup_pc = 32'h40; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_pred_npc = '0; upd_pred_taken = 1'b0;

    // Reset with an update in flight; the update must be discarded.
    go(32'h40, 1'b1, 32'h100, 1'b1, 32'h990, 32'h0, 1'b0);
    go(32'h40, 1'b1, 32'h100, 1'b1, 32'h990, 32'h0, 1'b0);
    go(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b1);
    chk("cold_pred_taken", 0, {31'd0, pt0}, 32'd0);
    chk("cold_pred_npc", 0, pn0, 32'h44);
    chk("cold_branch_cnt", 0, bc0, 32'd0);
    chk("cold_mispred_cnt", 0, mc0, 32'd0);
    chk("cold_pred_npc", 2, pn2, 32'h44);

    // Same-cycle lookup and allocate: old contents seen, new contents next cycle.
    go(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 32'h104, 1'b1);
    chk("conflict_pred_taken", 0, {31'd0, pt0}, 32'd0);
    chk("alloc_mispredict", 0, {31'd0, mp0}, 32'd1);
    go(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b1);
    chk("trained_pred_taken", 0, {31'd0, pt0}, 32'd1);
    chk("trained_pred_npc", 0, pn0, 32'h200);
    chk("trained_mispred_cnt", 0, mc0, 32'd1);

    repeat (2) go(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 32'h200, 1'b1);
    go(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b1);
    chk("untrained_pred_npc", 0, pn0, 32'h104);
    repeat (3) go(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 32'h104, 1'b1);
    // A single taken step from a floored counter must stay not-taken.
    go(32'h100, 1'b1, 32'h100, 1'b1, 32'h220, 32'h104, 1'b1);
    go(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b1);
    chk("floor_pred_taken", 0, {31'd0, pt0}, 32'd0);
    chk("floor_pred_npc", 0, pn0, 32'h104);

    go(32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b1);
    chk("alias_pred_npc", 0, pn0, 32'h144);
    go(32'h140, 1'b1, 32'h140, 1'b1, 32'h300, 32'h144, 1'b1);
    go(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b1);
    chk("evicted_pred_npc", 0, pn0, 32'h104);
    go(32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b1);
    chk("replaced_pred_npc", 0, pn0, 32'h300);

    // gshare history steering
    go(32'h20, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b0);
    go(32'h20, 1'b1, 32'h20, 1'b1, 32'h80, 32'h24, 1'b1);
    go(32'h20, 1'b1, 32'h20, 1'b0, 32'h0, 32'h24, 1'b1);
    go(32'h20, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b1);
    chk("gshare_hist10_npc", 1, pn1, 32'h24);
    go(32'h20, 1'b1, 32'h20, 1'b1, 32'h80, 32'h24, 1'b1);
    chk("gshare_mispredict", 1, {31'd0, mp1}, 32'd1);
    go(32'h20, 1'b1, 32'h68, 1'b0, 32'h0, 32'h6C, 1'b1);
    go(32'h20, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b1);
    chk("gshare_ctr10_taken", 1, {31'd0, pt1}, 32'd1);
    chk("gshare_ctr10_npc", 1, pn1, 32'h80);
    chk("gshare_branch_cnt", 1, bc1, 32'd4);
    chk("gshare_mispred_cnt", 1, mc1, 32'd2);
    chk("sat_branch_cnt_a", 2, {30'd0, bc2}, 32'd3);

    // Statistic saturation and npc wrap
    go(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b0);
    repeat (5) go(32'hFFFF_FFFC, 1'b1, 32'h300, 1'b0, 32'h0, 32'h0, 1'b1);
    go(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b1);
    chk("sat_branch_cnt", 2, {30'd0, bc2}, 32'd3);
    chk("sat_mispred_cnt", 2, {30'd0, mc2}, 32'd3);
    chk("wide_branch_cnt", 0, bc0, 32'd5);
    chk("wrap_pred_npc", 0, pn0, 32'h0);
    chk("wrap_pred_npc", 2, pn2, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      ra = rpc();
      rb = rpc();
      rt = $urandom & 32'hFFFF_FFFC;
      case ($urandom_range(0, 3))
        0:       rp = rb + 32'd4;
        1:       rp = rt;
        2:       rp = m_npc(0, rb);
        default: rp = $urandom & 32'hFFFF_FFFC;
      endcase
      go(ra, 1'($urandom_range(0, 1)), rb, 1'($urandom_range(0, 1)), rt, rp,
         ($urandom_range(0, 299) != 0));
    end

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
